fetch_unit: RTL and testbench

- Instruction-fetch stage that produces the pcp4f/rd pair consumed by the IF/ID pipeline register; it is the write side of that interface.
- Owns the PC and runs a hold-until-ready handshake to instruction memory, which may take several cycles to answer.
- Presents one fetched instruction at a time, and presents a NOP while no instruction is available.
- Honours fetch stall and branch/jump redirects resolved in decode.

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from a hold-until-ready memory
// port and presents one instruction (or a NOP bubble) to the IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallf,
  input  logic        pcsrcd,
  input  logic [31:0] pcbranchd,
  input  logic        jumpd,
  input  logic [31:0] pcjumpd,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcf,
  output logic [31:0] pcp4f,
  output logic [31:0] rd,
  output logic        validf
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] pcp4f_q, pcp4f_d;
  logic [31:0] tgt_q, tgt_d;
  logic        validf_q, validf_d;

  logic        redir;
  logic [31:0] redir_sel;
  logic [31:0] redir_tgt;

  assign redir     = jumpd | pcsrcd;
  assign redir_sel = jumpd ? pcjumpd : pcbranchd;
  assign redir_tgt = redir_sel & ~32'h0000_0003;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pcf_q    <= RESET_PC;
      rd_q     <= 32'h0;
      pcp4f_q  <= 32'h0;
      tgt_q    <= 32'h0;
      validf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcf_q    <= pcf_d;
      rd_q     <= rd_d;
      pcp4f_q  <= pcp4f_d;
      tgt_q    <= tgt_d;
      validf_q <= validf_d;
    end
  end

  // Memory handshake: imem_req/imem_addr stay asserted and unchanged from the
  // first request cycle up to and including the cycle imem_ready is seen;
  // imem_rdata is only meaningful in that imem_ready cycle.
  always_comb begin
    state_d  = state_q;
    pcf_d    = pcf_q;
    rd_d     = rd_q;
    pcp4f_d  = pcp4f_q;
    tgt_d    = tgt_q;
    validf_d = validf_q;
    case (state_q)
      FETCH: begin
        if (imem_ready) begin
          if (redir) begin
            pcf_d = redir_tgt;
          end else begin
            rd_d     = imem_rdata;
            pcp4f_d  = pcf_q + 32'd4;
            validf_d = 1'b1;
            state_d  = HOLD;
          end
        end else if (redir) begin
          tgt_d   = redir_tgt;
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (redir) begin
          pcf_d    = redir_tgt;
          validf_d = 1'b0;
          rd_d     = 32'h0;
          state_d  = FETCH;
        end else if (!stallf) begin
          pcf_d    = pcf_q + 32'd4;
          validf_d = 1'b0;
          rd_d     = 32'h0;
          state_d  = FETCH;
        end
      end
      DRAIN: begin
        // pcf still holds the in-flight address; the stale reply is dropped.
        if (imem_ready) begin
          pcf_d   = redir ? redir_tgt : tgt_q;
          state_d = FETCH;
        end else if (redir) begin
          tgt_d = redir_tgt;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign imem_req  = rst_n & ((state_q == FETCH) | (state_q == DRAIN));
  assign imem_addr = pcf_q;
  assign pcf       = pcf_q;
  assign pcp4f     = pcp4f_q;
  assign rd        = rd_q;
  assign validf    = validf_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stimulus
// against a transaction-level reference model and a variable-latency memory.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallf, pcsrcd, jumpd, imem_ready;
  logic [31:0] pcbranchd, pcjumpd, imem_rdata;
  logic        imem_req, validf;
  logic [31:0] imem_addr, pcf, pcp4f, rd;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stallf     (stallf),
    .pcsrcd     (pcsrcd),
    .pcbranchd  (pcbranchd),
    .jumpd      (jumpd),
    .pcjumpd    (pcjumpd),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .pcf        (pcf),
    .pcp4f      (pcp4f),
    .rd         (rd),
    .validf     (validf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: PC, presented instruction, and a pending redirect that
  // is applied when the in-flight fetch finally returns.
  logic [31:0] m_pc, m_rd, m_pcp4, m_tgt;
  logic        m_valid, m_pend;

  // Memory model state
  int          age, cur_lat, lat_fix;
  logic        fixed_en;
  logic [31:0] fixed_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (fixed_en) return fixed_data;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic model_reset();
    m_pc    = RST_PC;
    m_rd    = 32'h0;
    m_pcp4  = 32'h0;
    m_tgt   = 32'h0;
    m_valid = 1'b0;
    m_pend  = 1'b0;
    age     = 0;
  endtask

  task automatic check_outputs();
    check("pcf", pcf, m_pc);
    check("validf", {31'b0, validf}, {31'b0, m_valid});
    check("rd", rd, m_rd);
    check("pcp4f", pcp4f, m_pcp4);
    check("imem_req", {31'b0, imem_req}, {31'b0, !m_valid});
    if (!m_valid) check("imem_addr", imem_addr, m_pc);
  endtask

  // One clock: drive inputs at negedge, update the model at the edge, then
  // compare all outputs just after the edge.
  task automatic cycle(input logic st, input logic jd, input logic [31:0] jt,
                       input logic bd, input logic [31:0] bt);
    logic        rdy, req_s, redir;
    logic [31:0] data, tgt;
    @(negedge clk);
    stallf = st; jumpd = jd; pcjumpd = jt; pcsrcd = bd; pcbranchd = bt;
    req_s = imem_req;
    rdy   = 1'b0;
    if (req_s) begin
      if (age == 0) cur_lat = (lat_fix != 0) ? lat_fix : $urandom_range(1, 4);
      rdy = (age + 1 >= cur_lat);
    end
    data = rdy ? mem_word(imem_addr) : $urandom;
    imem_ready = rdy;
    imem_rdata = data;
    @(posedge clk);
    if (req_s) age = rdy ? 0 : age + 1;
    redir = jd | bd;
    tgt   = (jd ? jt : bt) & 32'hFFFF_FFFC;
    if (m_valid) begin
      if (redir) begin
        m_pc = tgt; m_valid = 1'b0; m_rd = 32'h0;
      end else if (!st) begin
        m_pc = m_pc + 32'd4; m_valid = 1'b0; m_rd = 32'h0;
      end
    end else begin
      if (redir) begin
        m_pend = 1'b1; m_tgt = tgt;
      end
      if (rdy) begin
        if (m_pend) begin
          m_pc = m_tgt; m_pend = 1'b0;
        end else begin
          m_valid = 1'b1; m_rd = data; m_pcp4 = m_pc + 32'd4;
        end
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic wait_hold();
    int n = 0;
    while (!m_valid && n < 20) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      n++;
    end
    check("wait_hold_timeout", {31'b0, m_valid}, 32'd1);
  endtask

  initial begin
    logic [31:0] saved_pc, saved_rd, saved_p4;
    rst_n = 1'b0; stallf = 1'b0; pcsrcd = 1'b0; jumpd = 1'b0;
    pcbranchd = 32'h0; pcjumpd = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;
    fixed_en = 1'b0; fixed_data = 32'h0; lat_fix = 0; cur_lat = 1;
    model_reset();
    #12;
    check("rst_pcf", pcf, RST_PC);
    check("rst_validf", {31'b0, validf}, 32'd0);
    check("rst_rd", rd, 32'h0);
    check("rst_pcp4f", pcp4f, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Two-cycle memory returning a fixed word.
    fixed_en = 1'b1; fixed_data = 32'h2008_0005; lat_fix = 2;
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t1_addr_held", imem_addr, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t1_rd", rd, 32'h2008_0005);
    check("t1_pcp4f", pcp4f, 32'h4);
    check("t1_validf", {31'b0, validf}, 32'd1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t1_pcf4", pcf, 32'h4);
    check("t1_addr4", imem_addr, 32'h4);

    // Stall in HOLD, then release advances by exactly one word.
    fixed_en = 1'b0;
    wait_hold();
    saved_pc = m_pc; saved_rd = m_rd; saved_p4 = m_pcp4;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      check("t2_rd_stable", rd, saved_rd);
      check("t2_p4_stable", pcp4f, saved_p4);
      check("t2_no_req", {31'b0, imem_req}, 32'd0);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t2_pc_adv", pcf, saved_pc + 32'd4);

    // Branch with unaligned target while stalled in HOLD.
    cycle(1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    wait_hold();
    check("t3_hold_pc", pcf, 32'h40);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h103);
    check("t3_pcf", pcf, 32'h100);
    check("t3_addr", imem_addr, 32'h100);
    check("t3_validf", {31'b0, validf}, 32'd0);
    check("t3_rd", rd, 32'h0);

    // Two redirects during an outstanding fetch: latest one wins.
    wait_hold();
    cycle(1'b1, 1'b1, 32'h20, 1'b0, 32'h0);
    lat_fix = 3;
    cycle(1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    check("t4_addr_c1", imem_addr, 32'h20);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h90);
    check("t4_addr_c2", imem_addr, 32'h20);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t4_validf", {31'b0, validf}, 32'd0);
    check("t4_addr_new", imem_addr, 32'h90);

    // Jump beats branch.
    lat_fix = 2;
    wait_hold();
    cycle(1'b0, 1'b1, 32'h200, 1'b1, 32'h300);
    check("t5_pcf", pcf, 32'h200);

    // Asynchronous reset in the middle of a drain.
    lat_fix = 4;
    cycle(1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    stallf = 1'b0; jumpd = 1'b0; pcsrcd = 1'b0; imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_rst_pcf", pcf, RST_PC);
    check("t6_rst_validf", {31'b0, validf}, 32'd0);
    check("t6_rst_rd", rd, 32'h0);
    check("t6_rst_req", {31'b0, imem_req}, 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    lat_fix = 1;
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t6_clean_valid", {31'b0, validf}, 32'd1);
    check("t6_clean_p4", pcp4f, RST_PC + 32'd4);

    // PC wrap at the top of the address space.
    cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    wait_hold();
    check("t6_wrap_p4", pcp4f, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t6_wrap_pcf", pcf, 32'h0);

    // Random traffic: stalls, redirects, variable memory latency.
    lat_fix = 0;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, $urandom,
            $urandom_range(0, 7) == 0, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
